// File: rtl/prio_enc_scan_disp.sv
// N-channel priority encoder with input synchronisers, registered code and a 2-digit
// multiplexed seven-segment display. Optional sticky capture of the code: define HOLD_EN.
module prio_enc_scan_disp #(
  parameter int CH          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SCAN_DIV    = 1000,
  localparam int AW         = $clog2(CH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EI,
  input  logic [CH-1:0] I,
  input  logic          CLR,
  output logic [AW-1:0] A,
  output logic          GS,
  output logic          EO,
  output logic [6:0]    SEG,
  output logic [1:0]    DIG
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [6:0] font(input logic [3:0] d);
    logic [6:0] f;
    case (d)
      4'd0:    f = 7'h3F;
      4'd1:    f = 7'h06;
      4'd2:    f = 7'h5B;
      4'd3:    f = 7'h4F;
      4'd4:    f = 7'h66;
      4'd5:    f = 7'h6D;
      4'd6:    f = 7'h7D;
      4'd7:    f = 7'h07;
      4'd8:    f = 7'h7F;
      4'd9:    f = 7'h6F;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

  // Synchronisers reset to the inactive (high) level so nothing is seen as a request.
  logic [SYNC_STAGES-1:0] ei_sync;
  logic [CH-1:0]          i_sync [SYNC_STAGES];
  logic                   ei_s;
  logic [CH-1:0]          i_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ei_sync <= '1;
      // NOTE: the sync chain is a flop array, not RAM, so resetting every stage is legitimate.
      for (int s = 0; s < SYNC_STAGES; s++) i_sync[s] <= '1;
    end else begin
      ei_sync   <= {ei_sync[SYNC_STAGES-2:0], EI};
      i_sync[0] <= I;
      for (int s = 1; s < SYNC_STAGES; s++) i_sync[s] <= i_sync[s-1];
    end
  end

  assign ei_s = ei_sync[SYNC_STAGES-1];
  assign i_s  = i_sync[SYNC_STAGES-1];

  logic          req_any;
  logic [AW-1:0] req_idx;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int k = 0; k < CH; k++) begin
      if (!i_s[k]) begin
        req_any = 1'b1;
        req_idx = AW'(k);
      end
    end
  end

  logic [AW-1:0] a_d;
  logic          gs_d;
  logic          eo_d;

`ifdef HOLD_EN
  always_comb begin
    a_d  = '0;
    gs_d = 1'b1;
    eo_d = ei_s | req_any;
    // Clear beats a same-cycle request; a still-active request is taken next cycle.
    if (!ei_s && !CLR) begin
      if (req_any && (GS || req_idx > A)) begin
        a_d  = req_idx;
        gs_d = 1'b0;
      end else begin
        a_d  = A;
        gs_d = GS;
      end
    end
  end
`else
  logic unused_clr;
  assign unused_clr = CLR;

  always_comb begin
    a_d  = '0;
    gs_d = 1'b1;
    eo_d = ei_s | req_any;
    if (!ei_s && req_any) begin
      a_d  = req_idx;
      gs_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      A  <= '0;
      GS <= 1'b1;
      EO <= 1'b1;
    end else begin
      A  <= a_d;
      GS <= gs_d;
      EO <= eo_d;
    end
  end

  // Scan timing: dsel=0 shows units, dsel=1 shows tens.
  logic [CW-1:0] scan_cnt;
  logic          scan_tc;
  logic          dsel;
  logic [AW-1:0] disp_a;
  logic          disp_gs;

  assign scan_tc = (scan_cnt == CW'(SCAN_DIV - 1));

  // The displayed code is snapshotted at slot boundaries so a digit never tears mid-slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_cnt <= '0;
      dsel     <= 1'b0;
      disp_a   <= '0;
      disp_gs  <= 1'b1;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      dsel     <= ~dsel;
      disp_a   <= A;
      disp_gs  <= GS;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [6:0] seg_d;
  logic [1:0] dig_d;
  int unsigned disp_val;

  always_comb begin
    disp_val = 32'(disp_a);
    seg_d    = 7'h00;
    dig_d    = dsel ? 2'b01 : 2'b10;
    if (!disp_gs) begin
      if (!dsel)               seg_d = font(4'(disp_val % 10));
      else if (disp_val >= 10) seg_d = font(4'(disp_val / 10));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEG <= 7'h00;
      DIG <= 2'b11;
    end else begin
      SEG <= seg_d;
      DIG <= dig_d;
    end
  end

endmodule

// File: tb/tb_prio_enc_scan_disp.sv
// Scoreboard bench for prio_enc_scan_disp: expectations are queued as stimulus is driven and
// popped when the synchronised, registered result is due. Sticky-capture case under HOLD_EN.
module tb_prio_enc_scan_disp;

  localparam int SCAN  = 4;
  localparam int SCAN8 = 2;
  localparam logic [6:0] FONT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    logic [3:0] a;
    logic       gs;
    logic       eo;
  } enc_t;

  typedef struct {
    logic [6:0] units;
    logic [6:0] tens;
  } disp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ei  = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] req_n = '1;
  logic [7:0]  i8 = '1;
  logic [3:0]  a;
  logic        gs, eo;
  logic [6:0]  seg;
  logic [1:0]  dig;
  logic [2:0]  a8;
  logic        gs8, eo8;
  logic [6:0]  seg8;
  logic [1:0]  dig8;

  int n_total = 0;
  int n_pass  = 0;

  enc_t  enc_q[$];
  disp_t disp_q[$];

  always #5 clk = ~clk;

  prio_enc_scan_disp #(.CH(16), .SYNC_STAGES(2), .SCAN_DIV(SCAN)) dut (
    .CLK(clk), .RST(rst), .EI(ei), .I(req_n), .CLR(clr),
    .A(a), .GS(gs), .EO(eo), .SEG(seg), .DIG(dig)
  );

  prio_enc_scan_disp #(.CH(8), .SYNC_STAGES(2), .SCAN_DIV(SCAN8)) dut8 (
    .CLK(clk), .RST(rst), .EI(ei), .I(i8), .CLR(clr),
    .A(a8), .GS(gs8), .EO(eo8), .SEG(seg8), .DIG(dig8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic enc_t model_enc(input logic e, input logic [15:0] r);
    enc_t m;
    m.a  = '0;
    m.gs = 1'b1;
    m.eo = 1'b1;
    if (!e) begin
      m.eo = 1'b0;
      for (int k = 15; k >= 0; k--) begin
        if (!r[k]) begin
          m.a  = 4'(k);
          m.gs = 1'b0;
          m.eo = 1'b1;
          break;
        end
      end
    end
    return m;
  endfunction

  function automatic disp_t model_disp(input enc_t m);
    disp_t d;
    d.units = m.gs ? 7'h00 : FONT[m.a % 10];
    d.tens  = (m.gs || m.a < 10) ? 7'h00 : FONT[m.a / 10];
    return d;
  endfunction

  task automatic pop_enc(input string tag);
    enc_t e;
    e = enc_q.pop_front();
    check({tag, "/A"},  a,  e.a);
    check({tag, "/GS"}, gs, e.gs);
    check({tag, "/EO"}, eo, e.eo);
  endtask

  // Samples two full scan periods once the slot snapshot has caught up with A.
  task automatic pop_disp(input string tag);
    disp_t d;
    d = disp_q.pop_front();
    repeat (2 * SCAN + 2) @(negedge clk);
    for (int n = 0; n < 2 * SCAN; n++) begin
      @(negedge clk);
      if (dig == 2'b10) begin
        check({tag, "/units"}, seg, d.units);
      end else begin
        check({tag, "/dig"}, dig, 2'b01);
        check({tag, "/tens"}, seg, d.tens);
      end
    end
  endtask

  // Called at a falling edge; the result is due after three rising edges.
  task automatic apply(input string tag, input logic e, input logic [15:0] r, input bit with_disp);
    ei    = e;
    req_n = r;
    enc_q.push_back(model_enc(e, r));
    if (with_disp) disp_q.push_back(model_disp(model_enc(e, r)));
    repeat (3) @(negedge clk);
    pop_enc(tag);
    if (with_disp) pop_disp(tag);
  endtask

  task automatic push_exp(input logic [3:0] ea, input logic egs, input logic eeo);
    enc_t e;
    e.a  = ea;
    e.gs = egs;
    e.eo = eeo;
    enc_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int run;
    logic [1:0] prev;

    // Reset release: DIG idle until the first edge, then units digit.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rst0_dig_idle", dig, 2'b11);
    @(posedge clk);
    #1 check("rst0_dig_first", dig, 2'b10);
    @(negedge clk);

    // Test 1: reset mid-operation is immediate.
    apply("t1_pre", 1'b0, ~(16'h1 << 5), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_rst/A", a, 4'd0);
    check("t1_rst/GS", gs, 1'b1);
    check("t1_rst/EO", eo, 1'b1);
    check("t1_rst/SEG", seg, 7'h00);
    check("t1_rst/DIG", dig, 2'b11);
    req_n = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("t1_rel_dig_idle", dig, 2'b11);
    @(posedge clk);
    #1 check("t1_rel_dig_first", dig, 2'b10);
    @(negedge clk);

    // Test 2: two simultaneous requests, higher wins.
    apply("t2", 1'b0, ~((16'h1 << 12) | (16'h1 << 3)), 1'b1);
    apply("idle_a", 1'b1, '1, 1'b0);

    // Test 4: single-digit code with leading blank and scan period.
    apply("t4", 1'b0, ~(16'h1 << 7), 1'b1);
    prev = dig;
    cnt  = 0;
    while (dig == prev && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("t4_dig_toggle_seen", 32'(cnt < 20), 32'd1);
    prev = dig;
    run  = 0;
    while (dig == prev && run < 20) begin
      @(negedge clk);
      run++;
    end
    check("t4_dig_run", run, SCAN);
    apply("idle_b", 1'b1, '1, 1'b0);

    // Top channel, all-active, then enable pulled high mid-operation.
    apply("a15", 1'b0, ~(16'h1 << 15), 1'b1);
    apply("ei_high", 1'b1, ~(16'h1 << 15), 1'b1);
    apply("all_act", 1'b0, 16'h0000, 1'b0);
    apply("idle_c", 1'b1, '1, 1'b0);

    // Test 3: enabled with no request, then disable with latency check.
    apply("t3", 1'b0, '1, 1'b1);
    ei = 1'b1;
    enc_q.push_back(model_enc(1'b1, '1));
    repeat (2) @(negedge clk);
    check("t3_lat_eo", eo, 1'b0);
    @(negedge clk);
    pop_enc("t3_ei");

    // Test 5: 8-channel instance.
    ei = 1'b0;
    i8 = 8'hFE;
    enc_q.push_back(model_enc(1'b0, {8'hFF, 8'hFE}));
    repeat (3) @(negedge clk);
    begin
      enc_t e;
      e = enc_q.pop_front();
      check("t5_ch0/A", a8, e.a);
      check("t5_ch0/GS", gs8, e.gs);
    end
    repeat (2 * SCAN8 + 2) @(negedge clk);
    cnt = 0;
    while (dig8 != 2'b10 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_units_seg", seg8, 7'h3F);
    i8 = 8'h7E;
    enc_q.push_back(model_enc(1'b0, {8'hFF, 8'h7E}));
    repeat (3) @(negedge clk);
    begin
      enc_t e;
      e = enc_q.pop_front();
      check("t5_ch7/A", a8, e.a);
      check("t5_ch7/GS", gs8, e.gs);
    end
    i8 = '1;
    apply("idle_d", 1'b1, '1, 1'b0);
    ei = 1'b0;

`ifdef HOLD_EN
    // Test 6: sticky capture, replacement by higher index only, and clear priority.
    req_n = ~(16'h1 << 7);
    repeat (5) @(negedge clk);
    req_n = '1;
    push_exp(4'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    pop_enc("t6_held7");
    req_n = ~(16'h1 << 2);
    push_exp(4'd7, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    pop_enc("t6_lower_ign");
    req_n = ~(16'h1 << 9);
    push_exp(4'd9, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    pop_enc("t6_higher9");
    req_n = '1;
    push_exp(4'd9, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    pop_enc("t6_held9");
    clr = 1'b1;
    push_exp(4'd0, 1'b1, 1'b0);
    @(negedge clk);
    pop_enc("t6_clr");
    req_n = ~(16'h1 << 4);
    push_exp(4'd0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    pop_enc("t6_clr_wins");
    clr = 1'b0;
    push_exp(4'd4, 1'b0, 1'b1);
    @(negedge clk);
    pop_enc("t6_after_clr");
`else
    // Without sticky capture the code follows live requests and CLR has no effect.
    apply("live9", 1'b0, ~(16'h1 << 9), 1'b0);
    clr = 1'b1;
    push_exp(4'd9, 1'b0, 1'b1);
    @(negedge clk);
    clr = 1'b0;
    pop_enc("clr_ignored");
    apply("release", 1'b0, '1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
